// File: rtl/booth_seq_mul16.sv
// -----------------------------------------------------------------------------
// booth_seq_mul16 -- sequential signed 16x16 -> 32-bit radix-2 Booth multiplier
//
// Multiply stage of ALU16. Each Booth step takes two cycles: ADD (optionally
// add or subtract the multiplicand through a 17-bit ripple-carry adder) and
// SHIFT (arithmetic shift of {A,Q,Q_1}). Sixteen steps plus one output cycle
// give the product 33 edges after the start edge.
//
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous active-high reset
//   start  in   1      operation request, sampled only while idle
//   x      in   WIDTH  multiplicand (two's complement), captured with start
//   y      in   WIDTH  multiplier (two's complement), captured with start
//   busy   out  1      high while an operation is in flight
//   done   out  1      one-cycle pulse, z valid from this cycle on
//   z      out  2*W    signed product, held until the next completion
//
// Also contains rca17, the ripple-carry adder used for the add/sub step.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// rca17 -- parameterised ripple-carry adder (default 17 bits)
//
// Ports
//   a, b  in   W  addends
//   ci    in   1  carry in (1 together with ~b gives a-b)
//   sum   out  W  a + b + ci, modulo 2**W
//
// The carry out of the top bit is not produced: the multiplier keeps one
// guard bit in the accumulator, so the wrapped sum is always the exact result.
// -----------------------------------------------------------------------------
module rca17 #(
  parameter int W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum
);

  // c[i] is the carry into bit i
  logic [W-1:0] c;

  assign c[0] = ci;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      assign sum[gi] = a[gi] ^ b[gi] ^ c[gi];
      if (gi < W - 1) begin : g_carry
        assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
      end
    end
  endgenerate

endmodule

module booth_seq_mul16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   z
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int AW = WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t state_reg, state_next;

  logic [AW-1:0]    a_reg;   // accumulator with one guard bit
  logic [WIDTH-1:0] q_reg;   // multiplier, shifted out LSB first
  logic             q1_reg;  // previous Q[0]
  logic [AW-1:0]    m_reg;   // sign-extended multiplicand
  logic [CNT_W-1:0] cnt_reg;
  logic [2*WIDTH-1:0] z_reg;
  logic             done_reg;

  // Booth recoding of the current bit pair
  logic [1:0]    booth_pair;
  logic          do_add;
  logic          do_sub;
  logic [AW-1:0] add_b;
  logic          add_ci;
  logic [AW-1:0] add_sum;

  assign booth_pair = {q_reg[0], q1_reg};
  assign do_add     = (booth_pair == 2'b01);
  assign do_sub     = (booth_pair == 2'b10);

  // Subtraction is a + ~m + 1 through the same adder
  assign add_b  = do_sub ? ~m_reg : m_reg;
  assign add_ci = do_sub;

  rca17 #(.W(AW)) u_rca (
    .a   (a_reg),
    .b   (add_b),
    .ci  (add_ci),
    .sum (add_sum)
  );

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ADD;
        end
      end
      ADD: begin
        state_next = SHIFT;
      end
      SHIFT: begin
        if (cnt_reg == LAST_STEP) begin
          state_next = OUT;
        end else begin
          state_next = ADD;
        end
      end
      OUT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      q_reg    <= '0;
      q1_reg   <= 1'b0;
      m_reg    <= '0;
      cnt_reg  <= '0;
      z_reg    <= '0;
      done_reg <= 1'b0;
    end else begin
      // done is a single-cycle pulse following the OUT cycle
      done_reg <= (state_reg == OUT);
      case (state_reg)
        IDLE: begin
          if (start) begin
            m_reg   <= {x[WIDTH-1], x};
            q_reg   <= y;
            a_reg   <= '0;
            q1_reg  <= 1'b0;
            cnt_reg <= '0;
          end
        end
        ADD: begin
          // 00 / 11 leave the accumulator untouched
          if (do_add || do_sub) begin
            a_reg <= add_sum;
          end
        end
        SHIFT: begin
          // arithmetic shift right of {A,Q,Q_1}
          a_reg   <= {a_reg[AW-1], a_reg[AW-1:1]};
          q_reg   <= {a_reg[0], q_reg[WIDTH-1:1]};
          q1_reg  <= q_reg[0];
          cnt_reg <= cnt_reg + 1'b1;
        end
        OUT: begin
          // guard bit equals A[15] here, so it is dropped
          z_reg <= {a_reg[WIDTH-1:0], q_reg};
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign z    = z_reg;

endmodule
